// File: rtl/avst_packet_arbiter.sv
// Two-input Avalon-ST packet arbiter: grants whole packets (SOP..EOP) round-robin
// onto a single registered output stage feeding the pixel stream path.
module avst_packet_arbiter #(
    parameter int DATA_W  = 32,
    parameter int EMPTY_W = 2
) (
    input  logic               clk,
    input  logic               reset,

    output logic               in0_ready,
    input  logic               in0_valid,
    input  logic [DATA_W-1:0]  in0_data,
    input  logic               in0_startofpacket,
    input  logic               in0_endofpacket,
    input  logic [EMPTY_W-1:0] in0_empty,

    output logic               in1_ready,
    input  logic               in1_valid,
    input  logic [DATA_W-1:0]  in1_data,
    input  logic               in1_startofpacket,
    input  logic               in1_endofpacket,
    input  logic [EMPTY_W-1:0] in1_empty,

    input  logic               out_ready,
    output logic               out_valid,
    output logic [DATA_W-1:0]  out_data,
    output logic               out_startofpacket,
    output logic               out_endofpacket,
    output logic [EMPTY_W-1:0] out_empty,

    output logic [1:0]         grant,
    output logic [1:0]         err_drop
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT0 = 2'd1,
        GRANT1 = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic               lastGrant_q, lastGrant_d;
    logic [1:0]         errDrop_q, errDrop_d;
    logic               outValid_q, outValid_d;
    logic [DATA_W-1:0]  outData_q, outData_d;
    logic               outSop_q, outSop_d;
    logic               outEop_q, outEop_d;
    logic [EMPTY_W-1:0] outEmpty_q, outEmpty_d;

    logic               outFree;
    logic               accept;
    logic               elig0, elig1;

    assign outFree = !outValid_q || out_ready;
    assign elig0   = in0_valid && in0_startofpacket;
    assign elig1   = in1_valid && in1_startofpacket;

    always_comb begin
        state_d     = state_q;
        lastGrant_d = lastGrant_q;
        errDrop_d   = errDrop_q;
        in0_ready   = 1'b0;
        in1_ready   = 1'b0;
        accept      = 1'b0;
        case (state_q)
            IDLE: begin
                // Idle only opens a grant on SOP; any non-SOP beat offered now is an orphan and is swallowed.
                in0_ready = !in0_startofpacket;
                in1_ready = !in1_startofpacket;
                if (in0_valid && !in0_startofpacket) errDrop_d[0] = 1'b1;
                if (in1_valid && !in1_startofpacket) errDrop_d[1] = 1'b1;
                if (elig0 && elig1)
                    state_d = lastGrant_q ? GRANT0 : GRANT1;
                else if (elig0)
                    state_d = GRANT0;
                else if (elig1)
                    state_d = GRANT1;
            end
            GRANT0: begin
                in0_ready = outFree;
                accept    = in0_valid && outFree;
                if (accept && in0_endofpacket) begin
                    state_d     = IDLE;
                    lastGrant_d = 1'b0;
                end
            end
            GRANT1: begin
                in1_ready = outFree;
                accept    = in1_valid && outFree;
                if (accept && in1_endofpacket) begin
                    state_d     = IDLE;
                    lastGrant_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        outValid_d = outValid_q && !out_ready;
        outData_d  = outData_q;
        outSop_d   = outSop_q;
        outEop_d   = outEop_q;
        outEmpty_d = outEmpty_q;
        if (accept) begin
            outValid_d = 1'b1;
            if (state_q == GRANT1) begin
                outData_d  = in1_data;
                outSop_d   = in1_startofpacket;
                outEop_d   = in1_endofpacket;
                outEmpty_d = in1_empty;
            end else begin
                outData_d  = in0_data;
                outSop_d   = in0_startofpacket;
                outEop_d   = in0_endofpacket;
                outEmpty_d = in0_empty;
            end
        end
    end

    // lastGrant resets to port 1 so that port 0 wins the first tie.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            lastGrant_q <= 1'b1;
            errDrop_q   <= 2'b00;
            outValid_q  <= 1'b0;
            outData_q   <= '0;
            outSop_q    <= 1'b0;
            outEop_q    <= 1'b0;
            outEmpty_q  <= '0;
        end else begin
            state_q     <= state_d;
            lastGrant_q <= lastGrant_d;
            errDrop_q   <= errDrop_d;
            outValid_q  <= outValid_d;
            outData_q   <= outData_d;
            outSop_q    <= outSop_d;
            outEop_q    <= outEop_d;
            outEmpty_q  <= outEmpty_d;
        end
    end

    assign out_valid         = outValid_q;
    assign out_data          = outData_q;
    assign out_startofpacket = outSop_q;
    assign out_endofpacket   = outEop_q;
    assign out_empty         = outEmpty_q;
    assign grant             = {state_q == GRANT1, state_q == GRANT0};
    assign err_drop          = errDrop_q;

endmodule
